pdm_clock_sampler: RTL and testbench
====================================

Name: pdm_clock_sampler

Overview:
- Front end of the PDM microphone peripheral. Divides the system clock to drive the microphone's PDM clock pin.
- Synchronises the microphone data pin and captures one bit per PDM period on a selectable edge, which selects the L or R channel.
- Emits `pdm_bit` plus a one-cycle `pdm_bit_valid` strobe. This pair feeds the CIC decimator as its per-sample input and clock enable.

Parameters:
- DIV_WIDTH, 8, width of the half-period divider value `clk_div`.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  run request for the PDM clock.
- clk_div  in  DIV_WIDTH  PDM clock half-period, in clk cycles. 0 is treated as 1.
- sample_edge  in  1  capture edge: 0 = rising edge of `pdm_clk_out`, 1 = falling edge.
- pdm_data_in  in  1  raw microphone data pin, asynchronous to clk.
- pdm_clk_out  out  1  PDM clock to the microphone.
- pdm_bit  out  1  last captured PDM bit.
- pdm_bit_valid  out  1  one-cycle strobe marking a new `pdm_bit`.
- running  out  1  high while the PDM clock generator is active.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - Outputs: `pdm_clk_out`=0, `pdm_bit`=0, `pdm_bit_valid`=0, `running`=0.
  - Internal: counter=0, both synchroniser flops=0, shadow half `half_s`=1, shadow edge `edge_s`=0.
- Synchroniser: two-flop synchroniser on `pdm_data_in`; its output is `sync2`. Captured data is therefore `pdm_data_in` as it was 2-3 clk before the capture edge.
- States are IDLE (`running`=0) and RUN (`running`=1).
- IDLE:
  - Counter is held at 0 and `pdm_clk_out` is held at 0.
  - On the first clk edge with `enable`=1: go to RUN, set counter=0, `half_s`=max(`clk_div`,1), `edge_s`=`sample_edge`.
- RUN, every clk:
  - If counter == `half_s`-1: counter<=0 and `pdm_clk_out` toggles.
  - Otherwise: counter increments.
- Phase order: each period is a low phase followed by a high phase; the period boundary is the falling toggle. The first rising edge occurs `half_s` clk after `running` rises. Period = 2*`half_s` clk at 50% duty.
- Divider update: `half_s` and `edge_s` are reloaded from `clk_div`/`sample_edge` only at each falling toggle. Periods are therefore never truncated; a change made mid-period takes effect from the next low phase.
- Capture:
  - On the clk edge where `pdm_clk_out` toggles to the level selected by `edge_s`: `pdm_bit`<=`sync2` and `pdm_bit_valid`<=1.
  - Both are visible in the same cycle as the new `pdm_clk_out` level.
  - `pdm_bit_valid` returns to 0 on the next clk. Exactly one strobe per PDM period.
- Stop:
  - If `enable`=0 at a falling toggle: `pdm_clk_out` goes to 0, and `running` and counter go to 0 on that same edge.
  - If `edge_s`=1, that final falling toggle still produces a capture.
  - Deasserting `enable` during the high phase (or earlier in the period) never shortens a phase or produces a runt pulse.
  - `enable` is sampled only at falling toggles while in RUN. A deassert-reassert pulse that begins and ends between falling toggles is ignored.
- Restart: leaving RUN always gives at least one IDLE cycle (`running`=0) before RUN can resume via the IDLE rule.
- No capture ever occurs in IDLE.
- Data timing: correct microphone data timing requires `half_s` >= 3, to cover synchroniser latency. This is not enforced in hardware.

Test Plan:
1. Startup: `enable`=1, `clk_div`=4, `sample_edge`=0 after reset. Required response:
   - `running` rises 1 clk later.
   - `pdm_clk_out` first rises 4 clk after `running` rises, then toggles every 4 clk (period 8).
   - `pdm_bit_valid` pulses for 1 clk coincident with each rising edge.
2. Data capture: `clk_div`=4, `sample_edge`=0. Change `pdm_data_in` 1 clk after each falling edge with the sequence 1,0,1,1. Required: the `pdm_bit` values at successive strobes are 1,0,1,1. Repeat with `sample_edge`=1, changing data 1 clk after each rising edge; required: strobes now at falling edges with the same sequence.
3. Divider zero: `clk_div`=0. Required: `pdm_clk_out` toggles every clk (period 2) and `pdm_bit_valid` asserts every 2nd clk.
4. Divider change: with `clk_div`=4, change to 2 mid high phase. Required: that high phase still lasts 4 clk, and all later phases last 2 clk.
5. Stop: `enable`=0 mid high phase with `clk_div`=4, `sample_edge`=1. Required:
   - The high phase completes at full length.
   - `pdm_clk_out` falls with one final strobe; `running`=0 on that same edge.
   - No further toggles or strobes. Re-enabling gives a first rise 4 clk after `running` rises again.
6. Async reset: assert `rst_n`=0 between clk edges during the high phase. Required: `pdm_clk_out`, `pdm_bit_valid` and `running` go to 0 immediately, with no capture; after release the generator stays in IDLE until `enable` is seen.

Source files
------------

// File: rtl/pdm_clock_sampler.sv
// PDM microphone front end: divides clk into the PDM clock, synchronises the
// data pin and captures one bit per PDM period on the selected clock edge.
module pdm_clock_sampler #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] clk_div,
   input  logic                 sample_edge,
   input  logic                 pdm_data_in,
   output logic                 pdm_clk_out,
   output logic                 pdm_bit,
   output logic                 pdm_bit_valid,
   output logic                 running
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [DIV_WIDTH-1:0] counter;
   logic [DIV_WIDTH-1:0] half_s;
   logic [DIV_WIDTH-1:0] div_eff;
   logic                 edge_s;
   logic                 sync1;
   logic                 sync2;
   logic                 toggle;
   logic                 fall;
   logic                 capture;

   assign div_eff = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;

   // A capture happens when the clock is about to move to the level chosen by
   // edge_s, i.e. when its current level equals edge_s.
   always_comb begin
      toggle  = (state == RUN) && (counter == (half_s - DIV_WIDTH'(1)));
      fall    = toggle && pdm_clk_out;
      capture = toggle && (pdm_clk_out == edge_s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (enable) state_next = RUN;
         RUN:  if (fall && !enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      running = (state == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pdm_data_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pdm_bit       <= 1'b0;
         pdm_bit_valid <= 1'b0;
      end else begin
         pdm_bit_valid <= capture;
         if (capture) pdm_bit <= sync2;
      end
   end

   // Divider settings are only reloaded at the falling toggle so a period in
   // flight is never truncated or stretched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter     <= '0;
         pdm_clk_out <= 1'b0;
         half_s      <= DIV_WIDTH'(1);
         edge_s      <= 1'b0;
      end else if (state == IDLE) begin
         counter     <= '0;
         pdm_clk_out <= 1'b0;
         if (enable) begin
            half_s <= div_eff;
            edge_s <= sample_edge;
         end
      end else if (toggle) begin
         counter     <= '0;
         pdm_clk_out <= ~pdm_clk_out;
         if (fall) begin
            half_s <= div_eff;
            edge_s <= sample_edge;
         end
      end else begin
         counter <= counter + DIV_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pdm_clock_sampler.sv
// Directed testbench for pdm_clock_sampler; outputs are sampled on the falling
// clk edge, k counts rising edges since the enable was first seen.
module tb_pdm_clock_sampler;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [7:0] clk_div;
   logic       sample_edge;
   logic       pdm_data_in;
   logic       pdm_clk_out;
   logic       pdm_bit;
   logic       pdm_bit_valid;
   logic       running;

   int n_checks;
   int n_pass;

   pdm_clock_sampler #(.DIV_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .clk_div       (clk_div),
      .sample_edge   (sample_edge),
      .pdm_data_in   (pdm_data_in),
      .pdm_clk_out   (pdm_clk_out),
      .pdm_bit       (pdm_bit),
      .pdm_bit_valid (pdm_bit_valid),
      .running       (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n       = 1'b0;
      enable      = 1'b0;
      clk_div     = 8'd4;
      sample_edge = 1'b0;
      pdm_data_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Raise enable and return at the negedge after the enabling posedge (k=0).
   task automatic start_run();
      enable = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pdm_clk_out !== 1'b0 || pdm_bit !== 1'b0 || pdm_bit_valid !== 1'b0 || running !== 1'b0)
         $display("[TB] FAIL reset_outputs got clk=%b bit=%b valid=%b run=%b exp all 0", pdm_clk_out, pdm_bit, pdm_bit_valid, running);
      else n_pass++;
      do_reset();
      n_checks++;
      if (running !== 1'b0 || pdm_clk_out !== 1'b0)
         $display("[TB] FAIL reset_idle got run=%b clk=%b exp 0 0", running, pdm_clk_out);
      else n_pass++;
   endtask

   task automatic test_startup();
      logic exp_clk;
      logic exp_v;
      do_reset();
      start_run();
      for (int k = 0; k < 20; k++) begin
         exp_clk = ((k / 4) % 2) == 1;
         exp_v   = (k % 8) == 4;
         n_checks++;
         if (pdm_clk_out !== exp_clk || pdm_bit_valid !== exp_v || running !== 1'b1)
            $display("[TB] FAIL startup k=%0d got clk=%b valid=%b run=%b exp clk=%b valid=%b run=1", k, pdm_clk_out, pdm_bit_valid, running, exp_clk, exp_v);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_capture(input logic edge_sel);
      logic [3:0] seq;
      logic       exp_v;
      int         n_strobe;
      int         n_drive;
      int         limit;
      int         first_drive;
      seq         = 4'b1101;
      n_strobe    = 0;
      n_drive     = 0;
      limit       = edge_sel ? 34 : 30;
      first_drive = edge_sel ? 5 : 1;
      do_reset();
      sample_edge = edge_sel;
      start_run();
      for (int k = 0; k < limit; k++) begin
         exp_v = edge_sel ? ((k % 8) == 0 && k > 0) : ((k % 8) == 4);
         n_checks++;
         if (pdm_bit_valid !== exp_v)
            $display("[TB] FAIL capture_valid edge=%b k=%0d got %b exp %b", edge_sel, k, pdm_bit_valid, exp_v);
         else n_pass++;
         if (exp_v && n_strobe < 4) begin
            n_checks++;
            if (pdm_bit !== seq[n_strobe])
               $display("[TB] FAIL capture_bit edge=%b strobe=%0d got %b exp %b", edge_sel, n_strobe, pdm_bit, seq[n_strobe]);
            else n_pass++;
            n_strobe++;
         end
         if (k >= first_drive && ((k - first_drive) % 8) == 0 && n_drive < 4) begin
            pdm_data_in = seq[n_drive];
            n_drive++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (n_strobe !== 4)
         $display("[TB] FAIL capture_count edge=%b got %0d exp 4", edge_sel, n_strobe);
      else n_pass++;
   endtask

   task automatic test_div_zero();
      logic exp_clk;
      do_reset();
      clk_div = 8'd0;
      start_run();
      for (int k = 0; k < 10; k++) begin
         exp_clk = (k % 2) == 1;
         n_checks++;
         if (pdm_clk_out !== exp_clk || pdm_bit_valid !== exp_clk)
            $display("[TB] FAIL div_zero k=%0d got clk=%b valid=%b exp clk=%b valid=%b", k, pdm_clk_out, pdm_bit_valid, exp_clk, exp_clk);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_div_change();
      logic exp_clk;
      logic exp_v;
      do_reset();
      start_run();
      for (int k = 0; k < 18; k++) begin
         if (k < 4) exp_clk = 1'b0;
         else if (k < 8) exp_clk = 1'b1;
         else exp_clk = (((k - 8) / 2) % 2) == 1;
         exp_v = (k == 4) || (k == 10) || (k == 14);
         n_checks++;
         if (pdm_clk_out !== exp_clk || pdm_bit_valid !== exp_v)
            $display("[TB] FAIL div_change k=%0d got clk=%b valid=%b exp clk=%b valid=%b", k, pdm_clk_out, pdm_bit_valid, exp_clk, exp_v);
         else n_pass++;
         if (k == 5) clk_div = 8'd2;
         @(negedge clk);
      end
   endtask

   task automatic test_enable_glitch();
      logic exp_clk;
      do_reset();
      start_run();
      for (int k = 0; k < 12; k++) begin
         exp_clk = ((k / 4) % 2) == 1;
         n_checks++;
         if (running !== 1'b1 || pdm_clk_out !== exp_clk)
            $display("[TB] FAIL enable_glitch k=%0d got run=%b clk=%b exp run=1 clk=%b", k, running, pdm_clk_out, exp_clk);
         else n_pass++;
         if (k == 1) enable = 1'b0;
         if (k == 3) enable = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_stop();
      logic exp_clk;
      logic exp_v;
      logic exp_run;
      do_reset();
      sample_edge = 1'b1;
      pdm_data_in = 1'b1;
      start_run();
      for (int k = 0; k < 25; k++) begin
         exp_clk = (k < 16) && (((k / 4) % 2) == 1);
         exp_v   = (k == 8) || (k == 16);
         exp_run = (k < 16);
         n_checks++;
         if (pdm_clk_out !== exp_clk || pdm_bit_valid !== exp_v || running !== exp_run)
            $display("[TB] FAIL stop k=%0d got clk=%b valid=%b run=%b exp clk=%b valid=%b run=%b", k, pdm_clk_out, pdm_bit_valid, running, exp_clk, exp_v, exp_run);
         else n_pass++;
         if (exp_v) begin
            n_checks++;
            if (pdm_bit !== 1'b1)
               $display("[TB] FAIL stop_bit k=%0d got %b exp 1", k, pdm_bit);
            else n_pass++;
         end
         if (k == 13) enable = 1'b0;
         @(negedge clk);
      end
      start_run();
      for (int k = 0; k < 6; k++) begin
         exp_clk = (k >= 4);
         n_checks++;
         if (running !== 1'b1 || pdm_clk_out !== exp_clk)
            $display("[TB] FAIL restart k=%0d got run=%b clk=%b exp run=1 clk=%b", k, running, pdm_clk_out, exp_clk);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      pdm_data_in = 1'b1;
      start_run();
      repeat (5) @(negedge clk);
      n_checks++;
      if (pdm_clk_out !== 1'b1)
         $display("[TB] FAIL areset_pre got clk=%b exp 1", pdm_clk_out);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (pdm_clk_out !== 1'b0 || pdm_bit_valid !== 1'b0 || running !== 1'b0 || pdm_bit !== 1'b0)
         $display("[TB] FAIL areset_now got clk=%b valid=%b run=%b bit=%b exp all 0", pdm_clk_out, pdm_bit_valid, running, pdm_bit);
      else n_pass++;
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (running !== 1'b0 || pdm_clk_out !== 1'b0 || pdm_bit_valid !== 1'b0)
            $display("[TB] FAIL areset_idle k=%0d got run=%b clk=%b valid=%b exp 0 0 0", k, running, pdm_clk_out, pdm_bit_valid);
         else n_pass++;
      end
      start_run();
      n_checks++;
      if (running !== 1'b1)
         $display("[TB] FAIL areset_resume got run=%b exp 1", running);
      else n_pass++;
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b1;
      enable      = 1'b0;
      clk_div     = 8'd4;
      sample_edge = 1'b0;
      pdm_data_in = 1'b0;
      @(negedge clk);
      test_reset();
      test_startup();
      test_capture(1'b0);
      test_capture(1'b1);
      test_div_zero();
      test_div_change();
      test_enable_glitch();
      test_stop();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
